ex_mem_pipe_stage: RTL
======================

Name: ex_mem_pipe_stage

Overview:
- Parametrised EX→MEM pipeline register for the CPU32 core. Sits between execute and memory stages.
- Carries N memory-op channels with 1-cycle latency, a register-writeback bundle through a configurable-depth delay line, and a 1-cycle proceed flag.
- Adds what the first-generation passthrough lacks: stall, flush, in-flight writeback count and a register-hazard compare against every in-flight destination.

Parameters:
- ADDR_W, 32, memory-op address width
- MOP_W, 4, memory-op code width per channel
- MEM_CH, 2, number of memory-op channels
- REG_W, 5, register index width
- ROP_W, 4, register-writeback op width (0 = NOP)
- RWB_CH, 2, register indices per writeback bundle
- RWB_DELAY, 2, writeback delay-line depth in cycles, legal range 1..8
- CNT_W, $clog2(RWB_DELAY+1), width of the in-flight counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- stall  in  1  hold all stage registers
- flush  in  1  kill contents, cleared ops
- m_a  in  MEM_CH*ADDR_W  memory addresses; channel k at [k*ADDR_W +: ADDR_W]
- m_op  in  MEM_CH*MOP_W  memory op codes
- r_a  in  RWB_CH*REG_W  writeback register indices
- r_op  in  ROP_W  writeback op
- r_proceed  in  1  proceed flag from mem
- hz_reg  in  REG_W  register index to check for hazard
- qm_a  out  MEM_CH*ADDR_W  memory addresses, delayed 1
- qm_op  out  MEM_CH*MOP_W  memory ops, delayed 1
- d1_r_a  out  RWB_CH*REG_W  writeback indices, stage 1
- d1_r_op  out  ROP_W  writeback op, stage 1
- qr_a  out  RWB_CH*REG_W  writeback indices, stage RWB_DELAY
- qr_op  out  ROP_W  writeback op, stage RWB_DELAY
- qr_proceed  out  1  proceed, delayed 1
- inflight  out  CNT_W  count of delay stages holding nonzero op
- hz_hit  out  1  hazard match

Behaviour:
- Reset: rst=0 at a rising edge zeroes every stage register. All outputs are then 0, including inflight and hz_hit. Reset has priority over flush and stall, and may assert mid-stream.
- Priority on each edge: reset > flush > stall > normal.
- Normal operation:
  - qm_a/qm_op ← m_a/m_op (latency 1).
  - qr_proceed ← r_proceed (latency 1).
  - Delay line stage[1] ← {r_a, r_op}; stage[i] ← stage[i-1] for i=2..RWB_DELAY.
  - d1_r_* presents stage[1]; qr_* presents stage[RWB_DELAY]. With RWB_DELAY=1 the two are identical, giving latency RWB_DELAY.
- Stall (flush=0): every register holds, including qr_proceed. Inputs are ignored that cycle.
- Flush:
  - Clears qm_op, all stage ops and qr_proceed to 0.
  - Address and index fields load normally; they are don't-care while the op is 0.
  - Flush with stall asserted still clears.
- inflight: combinational popcount of stages 1..RWB_DELAY with op≠0. Maximum value is RWB_DELAY; it cannot overflow by construction.
- hz_hit: combinational.
  - Asserts when hz_reg≠0 AND some stage s has op≠0 AND some channel c in s has r_a index == hz_reg.
  - Register 0 never hits.
  - Reflects current register state only, not the inputs of the current cycle.
- No handshake back-pressure beyond stall. Upstream must hold inputs stable during stall if it needs them retained.

Decomposition:
- Shared package cpu32_pipe_pkg holds:
  - constants ROP_NOP=0, MOP_NOP=0, REG_ZERO=0
  - defaults for ADDR_W/REG_W/ROP_W
  - packed typedef for the writeback bundle {idx[RWB_CH], op}
- One natural sub-module: rwb_delay_line. It is a parametrised shift line with stall/flush, exposing all stages for the hazard compare and popcount. The top instantiates it plus the memory/proceed registers and the combinational compare.

Test Plan:
- Reset mid-stream: run traffic, drive rst=0 one cycle → next cycle all outputs 0 and inflight=0; resume with r_op=3, r_a={7,9} → qr_op=3, qr_a={7,9} exactly RWB_DELAY cycles later.
- Latency: m_a={0x1000,0x2000}, m_op={2,5} for one cycle → qm_* show them on the next cycle only; r_op=4 → d1_r_op=4 after 1 cycle, qr_op=4 after RWB_DELAY cycles (repeat with RWB_DELAY=1 and 4).
- Stall: fill the line with ops 1,2, stall 3 cycles → all outputs and inflight=2 frozen; release → shifting resumes with no lost or duplicated entries.
- Flush with stall: line holds ops 1,2, assert flush+stall → next cycle qm_op=0, qr_op=0, d1_r_op=0, qr_proceed=0, inflight=0.
- Hazard: stage holding r_a={0,12}, op=1 → hz_reg=12 gives hz_hit=1; hz_reg=0 gives 0; same indices with op=0 give 0.
- Back-to-back ops for RWB_DELAY+2 cycles → inflight saturates at RWB_DELAY and never exceeds it.

Source files
------------

// File: rtl/cpu32_pipe_pkg.sv
// cpu32_pipe_pkg: shared constants, default widths and writeback bundle type for the CPU32 pipeline
package cpu32_pipe_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int REG_W_DEF = 5;
  localparam int ROP_W_DEF = 4;
  localparam int RWB_CH_DEF = 2;
  localparam logic [ROP_W_DEF-1:0] ROP_NOP = '0;
  localparam logic [3:0] MOP_NOP = '0;
  localparam logic [REG_W_DEF-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic [RWB_CH_DEF-1:0][REG_W_DEF-1:0] idx;
    logic [ROP_W_DEF-1:0] op;
  } rwb_bundle_t;
endpackage

// File: rtl/ex_mem_pipe_stage_if.sv
// ex_mem_pipe_stage_if: control, memory-op, writeback and hazard signals of the EX->MEM stage
interface ex_mem_pipe_stage_if #(
  parameter int ADDR_W = 32,
  parameter int MOP_W = 4,
  parameter int MEM_CH = 2,
  parameter int REG_W = 5,
  parameter int ROP_W = 4,
  parameter int RWB_CH = 2,
  parameter int RWB_DELAY = 2,
  parameter int CNT_W = $clog2(RWB_DELAY + 1)
);
  logic stall;
  logic flush;
  logic [MEM_CH*ADDR_W-1:0] m_a;
  logic [MEM_CH*MOP_W-1:0] m_op;
  logic [RWB_CH*REG_W-1:0] r_a;
  logic [ROP_W-1:0] r_op;
  logic r_proceed;
  logic [REG_W-1:0] hz_reg;
  logic [MEM_CH*ADDR_W-1:0] qm_a;
  logic [MEM_CH*MOP_W-1:0] qm_op;
  logic [RWB_CH*REG_W-1:0] d1_r_a;
  logic [ROP_W-1:0] d1_r_op;
  logic [RWB_CH*REG_W-1:0] qr_a;
  logic [ROP_W-1:0] qr_op;
  logic qr_proceed;
  logic [CNT_W-1:0] inflight;
  logic hz_hit;
  modport master (
    output stall, flush, m_a, m_op, r_a, r_op, r_proceed, hz_reg,
    input qm_a, qm_op, d1_r_a, d1_r_op, qr_a, qr_op, qr_proceed, inflight, hz_hit
  );
  modport slave (
    input stall, flush, m_a, m_op, r_a, r_op, r_proceed, hz_reg,
    output qm_a, qm_op, d1_r_a, d1_r_op, qr_a, qr_op, qr_proceed, inflight, hz_hit
  );
endinterface

// File: rtl/ex_mem_pipe_stage_rwb_delay_line.sv
// rwb_delay_line: writeback shift line with stall/flush, every stage exposed for hazard checks
module rwb_delay_line #(
  parameter int IDX_W = 10,
  parameter int OP_W = 4,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic flush,
  input  logic [IDX_W-1:0] idx_in,
  input  logic [OP_W-1:0] op_in,
  output logic [DEPTH-1:0][IDX_W-1:0] idx_q,
  output logic [DEPTH-1:0][OP_W-1:0] op_q
);
  logic [DEPTH-1:0][IDX_W-1:0] idx_nxt;
  logic [DEPTH-1:0][OP_W-1:0] op_nxt;
  if (DEPTH == 1) begin : g_one
    assign idx_nxt = idx_in;
    assign op_nxt = op_in;
  end else begin : g_many
    assign idx_nxt = {idx_q[DEPTH-2:0], idx_in};
    assign op_nxt = {op_q[DEPTH-2:0], op_in};
  end
  // flush still shifts indices; they are meaningless once every op is cleared
  always_ff @(posedge clk)
    if (!rst) begin
      idx_q <= '0;
      op_q <= '0;
    end else if (flush) begin
      idx_q <= idx_nxt;
      op_q <= '0;
    end else if (!stall) begin
      idx_q <= idx_nxt;
      op_q <= op_nxt;
    end
endmodule

// File: rtl/ex_mem_pipe_stage.sv
// ex_mem_pipe_stage: EX->MEM register with stall/flush, writeback delay line, in-flight count and hazard compare
module ex_mem_pipe_stage
  import cpu32_pipe_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int MOP_W = 4,
  parameter int MEM_CH = 2,
  parameter int REG_W = REG_W_DEF,
  parameter int ROP_W = ROP_W_DEF,
  parameter int RWB_CH = RWB_CH_DEF,
  parameter int RWB_DELAY = 2,
  parameter int CNT_W = $clog2(RWB_DELAY + 1)
) (
  input logic clk,
  input logic rst,
  ex_mem_pipe_stage_if.slave bus
);
  logic [RWB_DELAY-1:0][RWB_CH*REG_W-1:0] st_a;
  logic [RWB_DELAY-1:0][ROP_W-1:0] st_op;
  logic [CNT_W-1:0] cnt;
  logic hit;
  rwb_delay_line #(.IDX_W(RWB_CH*REG_W), .OP_W(ROP_W), .DEPTH(RWB_DELAY)) u_rwb (
    .clk(clk), .rst(rst), .stall(bus.stall), .flush(bus.flush),
    .idx_in(bus.r_a), .op_in(bus.r_op), .idx_q(st_a), .op_q(st_op)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      bus.qm_a <= '0;
      bus.qm_op <= '0;
      bus.qr_proceed <= 1'b0;
    end else if (bus.flush) begin
      bus.qm_a <= bus.m_a;
      bus.qm_op <= '0;
      bus.qr_proceed <= 1'b0;
    end else if (!bus.stall) begin
      bus.qm_a <= bus.m_a;
      bus.qm_op <= bus.m_op;
      bus.qr_proceed <= bus.r_proceed;
    end
  assign bus.d1_r_a = st_a[0];
  assign bus.d1_r_op = st_op[0];
  assign bus.qr_a = st_a[RWB_DELAY-1];
  assign bus.qr_op = st_op[RWB_DELAY-1];
  // only live stages count toward inflight or can raise a hazard
  always_comb begin
    cnt = '0;
    hit = 1'b0;
    for (int s = 0; s < RWB_DELAY; s++)
      if (|st_op[s]) begin
        cnt = cnt + CNT_W'(1);
        for (int c = 0; c < RWB_CH; c++)
          hit = hit | (st_a[s][c*REG_W +: REG_W] == bus.hz_reg);
      end
    bus.inflight = cnt;
    bus.hz_hit = hit & (bus.hz_reg != '0);
  end
endmodule
